// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / memory-wait controller.
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load in Execute
//   FWD_*           : ALU operand select encodings driven on ForwardAE/BE
//   state_t         : data-memory access sequencer states
package pipeline_ctrl_pkg;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_M  = 2'b10;  // Memory-stage ALU result

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ABORT
    } state_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one ALU source operand.
//   RsE        in  source register of the operand in Execute
//   RdM, RdW   in  destination registers in Memory / Writeback
//   RegWriteM  in  Memory-stage instruction writes the register file
//   RegWriteW  in  Writeback-stage instruction writes the register file
//   ForwardE   out operand select (FWD_RF / FWD_W / FWD_M)
// The Memory stage holds the younger result, so it wins over Writeback.
// x0 is never forwarded.
module forwarding_unit (
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardE
);
    import pipeline_ctrl_pkg::*;

    always_comb begin
        ForwardE = FWD_RF;
        if (RegWriteM && (RdM != '0) && (RdM == RsE))
            ForwardE = FWD_M;
        else if (RegWriteW && (RdW != '0) && (RdW == RsE))
            ForwardE = FWD_W;
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard and memory-wait controller for the five-stage pipeline.
// Generates operand forwarding selects, load-use stalls, branch flushes and
// sequences variable-latency data-memory accesses (freeze F/D/E/M, bubble
// M/W). Keeps stall / flush performance counters and a sticky timeout flag.
//   clk, rst                 clock, asynchronous active-high reset
//   Rs1D, Rs2D               Decode source registers
//   Rs1E, Rs2E, RdE          Execute source / destination registers
//   RdM, RdW                 Memory / Writeback destination registers
//   RegWriteM, RegWriteW     register-write enables in Memory / Writeback
//   ResultSrcE               Execute result select (RESULT_SRC_LOAD = load)
//   PCSrcE                   branch / jump taken in Execute
//   MemReqM, MemAckM         Memory-stage access request / completion
//   DMemReq                  request to data memory
//   ForwardAE, ForwardBE     ALU operand selects
//   StallF/D/E/M             hold pipeline registers
//   FlushD/E/W               clear F/D, D/E, M/W registers
//   MemErr                   sticky memory-timeout flag
//   StallCycles, FlushCount  performance counters (wrap)
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             DMemReq,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);
    import pipeline_ctrl_pkg::*;

    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              lw_stall;
    logic              mem_stall;

    forwarding_unit u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardE  (ForwardAE)
    );

    forwarding_unit u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardE  (ForwardBE)
    );

    assign lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                       ((Rs1D == RdE) || (Rs2D == RdE));
    // ABORT releases the freeze so the faulting instruction drains into a
    // bubbled W.
    assign mem_stall = MemReqM && !MemAckM && (state != ABORT);

    assign StallM  = mem_stall;
    assign StallE  = mem_stall;
    assign StallF  = mem_stall || lw_stall;
    assign StallD  = mem_stall || lw_stall;
    assign FlushW  = mem_stall || (state == ABORT);
    // Branch / load-use events in frozen stages wait until the freeze ends.
    assign FlushD  = PCSrcE && !mem_stall;
    assign FlushE  = (PCSrcE || lw_stall) && !mem_stall;
    assign DMemReq = MemReqM && (state != ABORT) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            MemErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    if (mem_stall)
                        state <= WAIT;
                end
                WAIT: begin
                    if (wcnt != WCNT_W'(MEM_TIMEOUT))
                        wcnt <= wcnt + WCNT_W'(1);
                    // A withdrawn request also ends the wait; an ack without a
                    // request never reaches here as a completion.
                    if (MemAckM || !MemReqM) begin
                        state <= IDLE;
                    end else if (wcnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
                        state  <= ABORT;
                        MemErr <= 1'b1;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF)
                StallCycles <= StallCycles + CNT_W'(1);
            if (FlushD || FlushE)
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table of single-cycle vectors
// plus hand-written multi-cycle memory wait / timeout / reset sequences.
module tb_pipeline_stall_ctrl;

    localparam int TO = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MemReqM, MemAckM;
    logic          DMemReq;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW;
    logic          MemErr;
    logic [CW-1:0] StallCycles, FlushCount;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE  (ResultSrcE),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemAckM     (MemAckM),
        .DMemReq     (DMemReq),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushW      (FlushW),
        .MemErr      (MemErr),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pcsrc, mreq, mack;
        logic [1:0] fa, fb;
        logic       stf, ste, fld, fle, flw, dreq;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input int rs1d, input int rs2d, input int rs1e, input int rs2e, input int rde,
        input int rdm, input int rdw, input int rwm, input int rww, input int rsrc,
        input int pcsrc, input int mreq, input int mack,
        input int fa, input int fb, input int stf, input int ste,
        input int fld, input int fle, input int flw, input int dreq);
        vec_t v;
        v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e);
        v.rde  = 5'(rde);  v.rdm  = 5'(rdm);  v.rdw  = 5'(rdw);
        v.rwm  = 1'(rwm);  v.rww  = 1'(rww);  v.rsrc = 2'(rsrc);
        v.pcsrc = 1'(pcsrc); v.mreq = 1'(mreq); v.mack = 1'(mack);
        v.fa = 2'(fa); v.fb = 2'(fb);
        v.stf = 1'(stf); v.ste = 1'(ste); v.fld = 1'(fld); v.fle = 1'(fle);
        v.flw = 1'(flw); v.dreq = 1'(dreq);
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        RegWriteM = v.rwm; RegWriteW = v.rww; ResultSrcE = v.rsrc;
        PCSrcE = v.pcsrc; MemReqM = v.mreq; MemAckM = v.mack;
    endtask

    task automatic clr_in;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = '0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    endtask

    vec_t vecs[17];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_sc;
        int exp_fc;
        int n;

        //        rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc mrq mak  fa fb stf ste fld fle flw drq
        vecs[0]  = mk(0, 0, 5, 3, 0, 5, 5, 1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0); // M beats W
        vecs[1]  = mk(0, 0, 5, 3, 0, 0, 5, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0); // RdM=0 -> W
        vecs[2]  = mk(0, 0, 5, 6, 0, 6, 5, 1, 1, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0); // split A/B
        vecs[3]  = mk(0, 0, 5, 5, 0, 5, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // no writes
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // x0 never fwd
        vecs[5]  = mk(1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 1, 0, 0); // load-use Rs2D
        vecs[6]  = mk(9, 8, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // load, no dep
        vecs[7]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // ALU op, no stall
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0); // load to x0
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0); // branch
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0, 1); // zero-wait mem
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0); // stray ack
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 1, 1, 0, 0, 1, 1); // branch frozen
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 1, 1, 0, 1); // ack -> flush
        vecs[14] = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 0,   0, 0, 1, 1, 0, 0, 1, 1); // lw + mem wait
        vecs[15] = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 1, 1,   0, 0, 1, 0, 0, 1, 0, 1); // ack -> lw stall
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);

        // Reset values and behaviour during reset
        rst = 1'b1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        MemReqM = 1'b1;
        #1;
        chk("rst_dmemreq", 32'(DMemReq), 32'd0);
        chk("rst_stallf_follows", 32'(StallF), 32'd1);
        chk("rst_stallcycles", StallCycles, 32'd0);
        chk("rst_flushcount", FlushCount, 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        MemReqM = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vector table with running counter model
        exp_sc = 0;
        exp_fc = 0;
        for (int i = 0; i < 17; i++) begin
            cyc();
            chk($sformatf("v%0d_stallcycles", i), StallCycles, 32'(exp_sc));
            chk($sformatf("v%0d_flushcount", i), FlushCount, 32'(exp_fc));
            set_in(vecs[i]);
            #2;
            chk($sformatf("v%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("v%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
            chk($sformatf("v%0d_stallF", i), 32'(StallF), 32'(vecs[i].stf));
            chk($sformatf("v%0d_stallD", i), 32'(StallD), 32'(vecs[i].stf));
            chk($sformatf("v%0d_stallE", i), 32'(StallE), 32'(vecs[i].ste));
            chk($sformatf("v%0d_stallM", i), 32'(StallM), 32'(vecs[i].ste));
            chk($sformatf("v%0d_flushD", i), 32'(FlushD), 32'(vecs[i].fld));
            chk($sformatf("v%0d_flushE", i), 32'(FlushE), 32'(vecs[i].fle));
            chk($sformatf("v%0d_flushW", i), 32'(FlushW), 32'(vecs[i].flw));
            chk($sformatf("v%0d_dmemreq", i), 32'(DMemReq), 32'(vecs[i].dreq));
            exp_sc += int'(vecs[i].stf);
            exp_fc += int'(vecs[i].fld || vecs[i].fle);
        end
        cyc();
        chk("tbl_end_stallcycles", StallCycles, 32'(exp_sc));
        chk("tbl_end_flushcount", FlushCount, 32'(exp_fc));
        clr_in();

        // Three-cycle memory: ack on the 4th cycle of the request
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MemAckM = (i == 3);
            #2;
            chk($sformatf("mem3_c%0d_stallF", i), 32'(StallF), 32'(i < 3));
            chk($sformatf("mem3_c%0d_stallM", i), 32'(StallM), 32'(i < 3));
            chk($sformatf("mem3_c%0d_flushW", i), 32'(FlushW), 32'(i < 3));
            chk($sformatf("mem3_c%0d_dmemreq", i), 32'(DMemReq), 32'd1);
            cyc();
        end
        MemReqM = 1'b0;
        MemAckM = 1'b0;
        #2;
        chk("mem3_after_dmemreq", 32'(DMemReq), 32'd0);
        chk("mem3_after_stallF", 32'(StallF), 32'd0);
        exp_sc += 3;
        chk("mem3_stallcycles", StallCycles, 32'(exp_sc));

        // Timeout: 1 IDLE + TO WAIT cycles stalled, then one ABORT cycle
        cyc();
        MemReqM = 1'b1;
        for (int i = 0; i <= TO + 1; i++) begin
            #2;
            if (i <= TO) begin
                chk($sformatf("to_c%0d_stallF", i), 32'(StallF), 32'd1);
                chk($sformatf("to_c%0d_memerr", i), 32'(MemErr), 32'd0);
                chk($sformatf("to_c%0d_dmemreq", i), 32'(DMemReq), 32'd1);
            end else begin
                chk("to_abort_stallF", 32'(StallF), 32'd0);
                chk("to_abort_stallE", 32'(StallE), 32'd0);
                chk("to_abort_flushW", 32'(FlushW), 32'd1);
                chk("to_abort_dmemreq", 32'(DMemReq), 32'd0);
                MemReqM = 1'b0;
            end
            cyc();
        end
        exp_sc += TO + 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("to_post%0d_memerr", i), 32'(MemErr), 32'd1);
            chk($sformatf("to_post%0d_flushW", i), 32'(FlushW), 32'd0);
            cyc();
        end
        chk("to_stallcycles", StallCycles, 32'(exp_sc));
        chk("to_flushcount", FlushCount, 32'(exp_fc));

        // Reset pulsed in the 2nd WAIT cycle
        MemReqM = 1'b1;
        cyc();
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk("rstw_dmemreq", 32'(DMemReq), 32'd0);
        chk("rstw_stallcycles", StallCycles, 32'd0);
        chk("rstw_flushcount", FlushCount, 32'd0);
        chk("rstw_memerr", 32'(MemErr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        // A fresh IDLE start must take exactly 1 + TO stalled cycles to abort.
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (!StallF) break;
            n++;
            cyc();
        end
        chk("rstw_stall_len", 32'(n), 32'(TO + 1));
        chk("rstw_abort_flushW", 32'(FlushW), 32'd1);
        MemReqM = 1'b0;
        cyc();
        #1;
        chk("rstw_memerr_after", 32'(MemErr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
